// File: rtl/pending_encoder_32.sv
// Sticky 32-request pending register with a committed 5-bit index handshake.
// Define PENDING_ENCODER_ROUND_ROBIN_EN for rotating priority; default is lowest-index-wins.
module pending_encoder_32 (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] REQ,
    input  logic [31:0] MASK,
    input  logic        ACK,
    output logic        VALID,
    output logic [4:0]  IDX,
    output logic [31:0] PEND,
    output logic        OVR
);

    typedef enum logic {
        S_IDLE,
        S_PRESENT
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [4:0]  idx_q;
    logic [4:0]  idx_d;
    logic [31:0] pend_q;
    logic        ovr_q;

    logic        accept;
    logic [31:0] clr;
    logic [31:0] cand;
    logic        any;
    logic [4:0]  win;

    assign accept = (state_q == S_PRESENT) & ACK;
    assign clr    = accept ? (32'h1 << idx_q) : 32'h0;
    assign cand   = pend_q & MASK;
    assign any    = |cand;

`ifdef PENDING_ENCODER_ROUND_ROBIN_EN
    logic [4:0]  ptr_q;
    logic [63:0] dbl;
    logic [31:0] rot;
    logic [4:0]  off;

    // Rotate so the pointer position lands at bit 0, then add it back.
    assign dbl = {cand, cand} >> ptr_q;
    assign rot = dbl[31:0];

    always_comb begin
        off = 5'd0;
        for (int k = 31; k >= 0; k--) begin
            if (rot[k]) begin
                off = 5'(k);
            end
        end
    end

    assign win = off + ptr_q;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ptr_q <= 5'd0;
        end else if (accept) begin
            ptr_q <= idx_q + 5'd1;
        end
    end
`else
    always_comb begin
        win = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (cand[i]) begin
                win = 5'(i);
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            S_IDLE: begin
                if (any) begin
                    idx_d   = win;
                    state_d = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (ACK) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            idx_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // A new request on a bit wins over its own acknowledge clear.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pend_q <= 32'h0;
            ovr_q  <= 1'b0;
        end else begin
            pend_q <= (pend_q & ~clr) | REQ;
            ovr_q  <= ovr_q | (|(REQ & pend_q & ~clr));
        end
    end

    assign VALID = (state_q == S_PRESENT);
    assign IDX   = idx_q;
    assign PEND  = pend_q;
    assign OVR   = ovr_q;

endmodule
